counter_bus_sequencer: RTL and testbench
========================================

COUNTER_BUS_SEQUENCER -- requirements
Module: counter_bus_sequencer

Interface
REQ-001 Parameter NUM_REQ, default 2: number of requesters sharing the counter bus (range 2..4).
REQ-002 Parameter SETUP_CYC, default 2: cycles csq/abus/data are stable before the strobe (range 1..15).
REQ-003 Parameter STROBE_CYC, default 4: cycles wrq or rdq is held low (range 1..15).
REQ-004 Parameter HOLD_CYC, default 2: cycles csq/abus/data are held after the strobe rises (range 1..15).
REQ-005 Port sclk  input  1  sole clock, all state on its rising edge.
REQ-006 Port rst  input  1  reset, asynchronous, active-high.
REQ-007 Port req_valid  input  NUM_REQ  per-requester transaction request.
REQ-008 Port req_wr  input  NUM_REQ  per-requester direction: 1 write, 0 read.
REQ-009 Port req_addr  input  2*NUM_REQ  per-requester channel address, requester i in bits [2i+1:2i].
REQ-010 Port req_wdata  input  8*NUM_REQ  per-requester write data, requester i in bits [8i+7:8i].
REQ-011 Port req_ready  output  NUM_REQ  one-cycle accept pulse to the granted requester.
REQ-012 Port rsp_valid  output  1  one-cycle read-data-valid pulse.
REQ-013 Port rsp_id  output  2  index of the requester owning rsp_rdata.
REQ-014 Port rsp_rdata  output  8  read data captured from the counter bus.
REQ-015 Port abus  output  2  channel address to the counter.
REQ-016 Port csq, wrq, rdq  output  1 each  active-low chip select, write strobe, read strobe.
REQ-017 Port dbus_o  output  8; dbus_oe  output  1; dbus_i  input  8  split counter data bus.

Function
REQ-018 FSM states IDLE, SETUP, STROBE, HOLD; one transaction in flight at a time.
REQ-019 IDLE: when any req_valid=1, grant one requester, pulse its req_ready, latch wr/addr/wdata/id, go to SETUP next cycle.
REQ-020 SETUP (SETUP_CYC cycles): csq=0, abus=latched addr; for writes dbus_oe=1 and dbus_o=latched wdata.
REQ-021 STROBE (STROBE_CYC cycles): wrq=0 for writes, rdq=0 for reads; csq, abus, dbus_o unchanged.
REQ-022 Read data: dbus_i sampled on the last STROBE cycle into rsp_rdata.
REQ-023 HOLD (HOLD_CYC cycles): wrq=rdq=1, csq=0, abus/dbus_o/dbus_oe held; then IDLE.
REQ-024 rsp_valid pulses for exactly the first HOLD cycle for reads only; rsp_rdata and rsp_id stable until the next read response.
REQ-025 Transaction length = 1 + SETUP_CYC + STROBE_CYC + HOLD_CYC cycles; a granted requester can be re-granted no earlier than the following IDLE cycle.
REQ-026 wrq and rdq never low simultaneously; neither low while csq=1.
REQ-027 Phase counter is 4 bits, counts down, reloads on each state entry; never wraps below 0.
REQ-028 req_valid changes after the grant do not affect the in-flight transaction; non-granted requests stay pending (no drop).

Reset
REQ-029 rst=1 forces immediately: state IDLE, csq=wrq=rdq=1, abus=0, dbus_o=0, dbus_oe=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_rdata=0, arbiter pointer 0.
REQ-030 Reset mid-transaction aborts it with no rsp_valid; the first grant after reset release follows REQ-029 pointer state.

Configuration
REQ-031 Macro CNTSEQ_ROUND_ROBIN_EN defined: round-robin grant; search starts at (last granted index + 1) mod NUM_REQ.
REQ-032 Macro CNTSEQ_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; pointer logic absent.

Structure
REQ-033 Package cntseq_pkg holds the state enum, the 4-bit phase-count type, and the 2-bit channel-address and 8-bit data typedefs.
REQ-034 Grant logic lives in sub-module cntseq_arbiter (req vector + enable in, one-hot grant and index out).

Verification (defaults unless stated)
REQ-035 Write req0 addr=2 data=0x5A -> req_ready[0] 1 cycle; csq low 8 cycles; wrq low 4 cycles starting 2 cycles after csq falls; dbus_o=0x5A, dbus_oe=1 throughout csq low.
REQ-036 Read req1 addr=3, dbus_i=0x3C during strobe -> rdq low 4 cycles; rsp_valid 1 cycle in first HOLD cycle with rsp_rdata=0x3C, rsp_id=1.
REQ-037 req0 and req1 held valid continuously with CNTSEQ_ROUND_ROBIN_EN -> grants alternate 0,1,0,1, one per 9 cycles; without it -> req0 granted every transaction.
REQ-038 rst asserted in STROBE of a write -> same cycle csq=wrq=1, dbus_oe=0; no rsp_valid; next request after release completes normally.
REQ-039 SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1 back-to-back reads -> 4-cycle transactions, rdq and wrq never low together, csq high for exactly the IDLE cycle between them.

Source files
------------

// File: rtl/cntseq_pkg.sv
// cntseq_pkg: shared state, phase-count and bus types for the counter bus sequencer
package cntseq_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} state_t;
  typedef logic [3:0] phase_t;
  typedef logic [1:0] addr_t;
  typedef logic [7:0] data_t;
  function automatic phase_t phase_load(input int cyc);
    return phase_t'(cyc - 1);
  endfunction
endpackage

// File: rtl/cntseq_arbiter.sv
// cntseq_arbiter: one-hot grant among requesters; CNTSEQ_ROUND_ROBIN_EN selects round-robin over fixed priority
module cntseq_arbiter #(
  parameter int NUM_REQ = 2
) (
`ifdef CNTSEQ_ROUND_ROBIN_EN
  input  logic               clk,
  input  logic               rst,
`endif
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [1:0]         idx_o
);
  logic [NUM_REQ-1:0] cand;
`ifdef CNTSEQ_ROUND_ROBIN_EN
  logic [1:0]         ptr_q, ptr_d;
  logic [NUM_REQ-1:0] hi;
  // Requests at or above the pointer win first; otherwise wrap to the lowest index.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) hi[i] = 2'(i) >= ptr_q;
    cand  = |(req_i & hi) ? req_i & hi : req_i;
    ptr_d = (idx_o == 2'(NUM_REQ - 1)) ? 2'd0 : idx_o + 2'd1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) ptr_q <= 2'd0;
    else if (en_i && |req_i) ptr_q <= ptr_d;
`else
  assign cand = req_i;
`endif
  always_comb begin
    idx_o = 2'd0;
    for (int i = NUM_REQ - 1; i >= 0; i--) if (cand[i]) idx_o = 2'(i);
    for (int i = 0; i < NUM_REQ; i++) gnt_o[i] = en_i && cand[i] && (idx_o == 2'(i));
  end
endmodule

// File: rtl/counter_bus_sequencer.sv
// counter_bus_sequencer: shares a strobed counter bus among requesters; CNTSEQ_ROUND_ROBIN_EN selects round-robin grant
module counter_bus_sequencer import cntseq_pkg::*; #(
  parameter int NUM_REQ    = 2,
  parameter int SETUP_CYC  = 2,
  parameter int STROBE_CYC = 4,
  parameter int HOLD_CYC   = 2
) (
  input  logic                   sclk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [NUM_REQ-1:0]     req_wr,
  input  logic [2*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic                   rsp_valid,
  output logic [1:0]             rsp_id,
  output data_t                  rsp_rdata,
  output addr_t                  abus,
  output logic                   csq,
  output logic                   wrq,
  output logic                   rdq,
  output data_t                  dbus_o,
  output logic                   dbus_oe,
  input  data_t                  dbus_i
);
  state_t             state_q, state_d;
  phase_t             cnt_q, cnt_d;
  logic               wr_q, wr_d;
  addr_t              addr_q, addr_d;
  data_t              wdata_q, wdata_d, rdata_q, rdata_d;
  logic [1:0]         id_q, id_d, rsp_id_q, rsp_id_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [NUM_REQ-1:0] gnt;
  logic [1:0]         gnt_idx;
  logic               last, sel_wr;
  addr_t              sel_addr;
  data_t              sel_wdata;

  cntseq_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
`ifdef CNTSEQ_ROUND_ROBIN_EN
    .clk   (sclk),
    .rst   (rst),
`endif
    .req_i (req_valid),
    .en_i  (state_q == IDLE && !rst),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_comb begin
    sel_wr    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt[i]) begin
        sel_wr    = req_wr[i];
        sel_addr  = req_addr[2*i +: 2];
        sel_wdata = req_wdata[8*i +: 8];
      end
  end

  assign last = cnt_q == '0;

  // Counter holds at zero so an idle sequencer never wraps.
  always_comb begin
    state_d     = state_q;
    cnt_d       = last ? cnt_q : cnt_q - 4'd1;
    wr_d        = wr_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    id_d        = id_q;
    rdata_d     = rdata_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = 1'b0;
    case (state_q)
      IDLE: if (|gnt) begin
        state_d = SETUP;
        cnt_d   = phase_load(SETUP_CYC);
        wr_d    = sel_wr;
        addr_d  = sel_addr;
        wdata_d = sel_wdata;
        id_d    = gnt_idx;
      end
      SETUP: if (last) begin
        state_d = STROBE;
        cnt_d   = phase_load(STROBE_CYC);
      end
      STROBE: if (last) begin
        state_d     = HOLD;
        cnt_d       = phase_load(HOLD_CYC);
        rsp_valid_d = !wr_q;
        rdata_d     = wr_q ? rdata_q : dbus_i;
        rsp_id_d    = wr_q ? rsp_id_q : id_q;
      end
      default: if (last) state_d = IDLE;
    endcase
  end

  always_ff @(posedge sclk or posedge rst)
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      wr_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      id_q        <= 2'd0;
      rdata_q     <= '0;
      rsp_id_q    <= 2'd0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      wr_q        <= wr_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      id_q        <= id_d;
      rdata_q     <= rdata_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
    end

  assign req_ready = gnt;
  assign csq       = state_q == IDLE;
  assign wrq       = !(state_q == STROBE && wr_q);
  assign rdq       = !(state_q == STROBE && !wr_q);
  assign abus      = addr_q;
  assign dbus_oe   = state_q != IDLE && wr_q;
  assign dbus_o    = dbus_oe ? wdata_q : '0;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_rdata = rdata_q;
endmodule

// File: tb/tb_counter_bus_sequencer.sv
// tb_counter_bus_sequencer: scoreboard bench for default and minimum-timing sequencers
module tb_counter_bus_sequencer;
`ifdef CNTSEQ_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif
  typedef struct {bit wr; int a; int d; int cl; int sl; int so;} shape_t;

  logic sclk = 1'b0;
  always #5 sclk = ~sclk;

  logic rst_a = 1'b1, rst_b = 1'b1, sel = 1'b0;
  logic [1:0] req_valid = '0, req_wr = '0;
  logic [3:0] req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic [7:0] rd_val = '0;

  logic [1:0] ready_a, ready_b, rid_a, rid_b, abus_a, abus_b;
  logic rv_a, rv_b, csq_a, csq_b, wrq_a, wrq_b, rdq_a, rdq_b, oe_a, oe_b;
  logic [7:0] rdata_a, rdata_b, dbo_a, dbo_b, dbi_a, dbi_b;

  assign dbi_a = rdq_a ? 8'hEE : rd_val;
  assign dbi_b = rdq_b ? 8'hEE : rd_val;

  counter_bus_sequencer dut_a (
    .sclk(sclk), .rst(rst_a), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(ready_a), .rsp_valid(rv_a), .rsp_id(rid_a),
    .rsp_rdata(rdata_a), .abus(abus_a), .csq(csq_a), .wrq(wrq_a), .rdq(rdq_a),
    .dbus_o(dbo_a), .dbus_oe(oe_a), .dbus_i(dbi_a));

  counter_bus_sequencer #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_b (
    .sclk(sclk), .rst(rst_b), .req_valid(req_valid), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_ready(ready_b), .rsp_valid(rv_b), .rsp_id(rid_b),
    .rsp_rdata(rdata_b), .abus(abus_b), .csq(csq_b), .wrq(wrq_b), .rdq(rdq_b),
    .dbus_o(dbo_b), .dbus_oe(oe_b), .dbus_i(dbi_b));

  wire       m_rst   = sel ? rst_b : rst_a;
  wire [1:0] m_ready = sel ? ready_b : ready_a;
  wire       m_rv    = sel ? rv_b : rv_a;
  wire [1:0] m_rid   = sel ? rid_b : rid_a;
  wire [7:0] m_rdata = sel ? rdata_b : rdata_a;
  wire [1:0] m_abus  = sel ? abus_b : abus_a;
  wire       m_csq   = sel ? csq_b : csq_a;
  wire       m_wrq   = sel ? wrq_b : wrq_a;
  wire       m_rdq   = sel ? rdq_b : rdq_a;
  wire [7:0] m_dbo   = sel ? dbo_b : dbo_a;
  wire       m_oe    = sel ? oe_b : oe_a;

  int gq[$];
  int rq[$];
  shape_t sq[$];
  int n_chk = 0, n_pass = 0, cyc = 0, gap_g = 0, gap_c = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  task automatic miss(input string nm);
    n_chk++;
    $display("FAIL %s: event absent or unexpected at %0t", nm, $time);
  endtask

  // grant monitor
  int e_g, last_g = 0;
  bit had_g = 0;
  initial forever begin
    @(negedge sclk);
    cyc++;
    if (!m_rst && m_ready != 0) begin
      if (gq.size() == 0) miss("unexpected_grant");
      else begin
        e_g = gq.pop_front();
        chk("grant", int'(m_ready), 1 << e_g);
      end
      if (gap_g != 0 && had_g) chk("grant_gap", cyc - last_g, gap_g);
      had_g  = gap_g != 0;
      last_g = cyc;
    end
  end

  // response monitor
  int e_r;
  initial forever begin
    @(negedge sclk);
    if (!m_rst && m_rv) begin
      if (rq.size() == 0) miss("unexpected_rsp");
      else begin
        e_r = rq.pop_front();
        chk("rsp_id", int'(m_rid), e_r >> 8);
        chk("rsp_rdata", int'(m_rdata), e_r & 255);
      end
    end
  end

  // bus-shape monitor: one expected shape per csq-low burst
  shape_t cur;
  bit in_b = 0, ok = 1, had_c = 0;
  int cl = 0, sl = 0, so = -1, hi = 0;
  initial forever begin
    @(negedge sclk);
    if (m_rst) begin
      in_b = 0;
      hi   = 0;
    end else if (!m_csq) begin
      if (!in_b) begin
        in_b = 1; cl = 0; sl = 0; so = -1; ok = 1;
        if (gap_c != 0 && had_c) chk("csq_high_gap", hi, gap_c);
        had_c = gap_c != 0;
        if (sq.size() == 0) begin
          miss("unexpected_burst");
          cur = '{0, 0, 0, 0, 0, 0};
        end else cur = sq.pop_front();
      end
      cl++;
      if (!m_wrq || !m_rdq) begin
        if (sl == 0) so = cl - 1;
        sl++;
      end
      if (int'(m_abus) != cur.a || m_oe != cur.wr || int'(m_dbo) != cur.d ||
          (!m_wrq && !cur.wr) || (!m_rdq && cur.wr)) ok = 0;
    end else begin
      if (in_b) begin
        chk("csq_low_len", cl, cur.cl);
        chk("strobe_len", sl, cur.sl);
        chk("strobe_offset", so, cur.so);
        chk("bus_stable", int'(ok), 1);
        in_b = 0;
        hi   = 0;
      end
      hi++;
      if (!m_wrq || !m_rdq) miss("strobe_while_csq_high");
    end
  end

  task automatic wait_grant();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge sclk);
      if (m_ready != 0) break;
    end
    if (k == 40) miss("grant_timeout");
    @(posedge sclk);
    #1;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 40; k++) begin
      @(negedge sclk);
      if (m_csq) break;
    end
    if (k == 40) miss("done_timeout");
    @(posedge sclk);
    #1;
  endtask

  task automatic expect_txn(input int id, input bit wr, input int a, input int d, input int rd,
                            input int c, input int s, input int o);
    shape_t x;
    x.wr = wr; x.a = a; x.d = wr ? d : 0; x.cl = c; x.sl = s; x.so = o;
    gq.push_back(id);
    sq.push_back(x);
    if (!wr) rq.push_back(id * 256 + rd);
  endtask

  task automatic issue(input int id, input bit wr, input int a, input int d, input int rd);
    expect_txn(id, wr, a, d, rd, 8, 4, 2);
    if (!wr) rd_val = 8'(rd);
    req_wr[id] = wr;
    req_addr[2*id +: 2] = 2'(a);
    req_wdata[8*id +: 8] = 8'(d);
    req_valid[id] = 1'b1;
    wait_grant();
    req_valid[id] = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1);
  end

  initial begin
    int k;
    req_valid = 2'b11;
    repeat (3) @(posedge sclk);
    @(negedge sclk);
    chk("rst_csq", int'(m_csq), 1);
    chk("rst_wrq", int'(m_wrq), 1);
    chk("rst_rdq", int'(m_rdq), 1);
    chk("rst_abus", int'(m_abus), 0);
    chk("rst_dbus_o", int'(m_dbo), 0);
    chk("rst_dbus_oe", int'(m_oe), 0);
    chk("rst_req_ready", int'(m_ready), 0);
    chk("rst_rsp_valid", int'(m_rv), 0);
    chk("rst_rsp_id", int'(m_rid), 0);
    chk("rst_rsp_rdata", int'(m_rdata), 0);
    req_valid = 2'b00;
    @(posedge sclk);
    #1 rst_a = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    issue(0, 1, 2, 'h5A, 0);     wait_done();
    issue(1, 0, 3, 0, 'h3C);     wait_done();
    issue(0, 0, 1, 0, 'hA5);     wait_done();
    issue(1, 1, 0, 'hC3, 0);     wait_done();
    chk("rsp_rdata_held", int'(m_rdata), 'hA5);
    chk("rsp_id_held", int'(m_rid), 0);
    // abort a write in STROBE with an asynchronous reset
    issue(0, 1, 1, 'h77, 0);
    for (k = 0; k < 40; k++) begin
      @(negedge sclk);
      if (!m_wrq) break;
    end
    if (k == 40) miss("strobe_timeout");
    #2 rst_a = 1'b1;
    #1;
    chk("abort_csq", int'(m_csq), 1);
    chk("abort_wrq", int'(m_wrq), 1);
    chk("abort_dbus_oe", int'(m_oe), 0);
    chk("abort_dbus_o", int'(m_dbo), 0);
    repeat (2) @(posedge sclk);
    #1 rst_a = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    // both requesters held valid from a fresh pointer
    for (int n = 0; n < 4; n++) begin
      int g;
      g = RR ? n % 2 : 0;
      expect_txn(g, 1, g, g ? 'h22 : 'h11, 0, 8, 4, 2);
    end
    req_wr = 2'b11;
    req_addr = 4'b0100;
    req_wdata = 16'h2211;
    gap_g = 9;
    gap_c = 1;
    req_valid = 2'b11;
    repeat (4) wait_grant();
    req_valid = 2'b00;
    wait_done();
    gap_g = 0;
    gap_c = 0;
    issue(1, 0, 2, 0, 'h9C);     wait_done();
    // minimum-timing instance, back-to-back reads
    @(posedge sclk);
    #1;
    rst_a = 1'b1;
    sel = 1'b1;
    rst_b = 1'b0;
    repeat (2) @(posedge sclk);
    #1;
    rd_val = 8'h6B;
    for (int n = 0; n < 3; n++) expect_txn(0, 0, 3, 0, 'h6B, 3, 1, 1);
    gap_g = 4;
    gap_c = 1;
    req_wr[0] = 1'b0;
    req_addr[1:0] = 2'd3;
    req_valid = 2'b01;
    repeat (3) wait_grant();
    req_valid = 2'b00;
    wait_done();
    gap_g = 0;
    gap_c = 0;
    repeat (3) @(posedge sclk);
    chk("grants_left", gq.size(), 0);
    chk("rsps_left", rq.size(), 0);
    chk("bursts_left", sq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
